// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply / divide unit (MULT, MULTU, DIV, DIVU).
//
// Ports:
//   clk, reset   - clock (posedge) and asynchronous active-high reset
//   start        - request a new operation
//   op           - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   dataa, datab - multiplicand/dividend and multiplier/divisor (sampled with start)
//   busy         - operation in progress
//   done         - one-cycle pulse: hi/lo/dbz were just updated
//   dbz          - divide-by-zero flag of the last completed operation
//   hi, lo       - product {hi,lo}, or remainder (hi) and quotient (lo)
//
// Handshake: start is honoured at a posedge only while busy=0 (IDLE or FIN);
// while busy=1 it is ignored. Operands are captured at that acceptance edge,
// and hi/lo/dbz change only at the completion edge, after which done is high
// for exactly one cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        busy,
    output logic        done,
    output logic        dbz,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t      state, state_nxt;
    logic [4:0]  count;
    logic        is_div;
    logic        neg_q;      // product / quotient must be negated
    logic        neg_r;      // remainder must be negated (dividend was negative)
    logic [31:0] a_mag;      // |dataa|
    logic [31:0] b_mag;      // |datab| (multiplicand for mult, divisor for div)
    logic [31:0] p_hi;       // partial product upper word / partial remainder
    logic [31:0] p_lo;       // multiplier bits / dividend bits shifting into quotient

    // Acceptance-side operand conditioning
    logic        op_signed;
    logic [31:0] abs_a, abs_b;
    logic        accept;

    assign op_signed = ~op[0];
    assign abs_a     = (op_signed && dataa[31]) ? (32'd0 - dataa) : dataa;
    assign abs_b     = (op_signed && datab[31]) ? (32'd0 - datab) : datab;
    assign accept    = start && (state != S_RUN);

    // One iteration of the shared datapath
    logic [32:0] m_add;
    logic [32:0] d_shift, d_trial;
    logic [31:0] s_hi, s_lo;

    always_comb begin
        m_add   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_mag} : 33'd0);
        d_shift = {p_hi, p_lo[31]};
        d_trial = d_shift - {1'b0, a_mag_or_div()};
        s_hi    = 32'd0;
        s_lo    = 32'd0;
        if (is_div) begin
            // Restoring step: the partial remainder is always below the
            // divisor, so a set bit 32 of the trial means it went negative.
            if (!d_trial[32]) begin
                s_hi = d_trial[31:0];
                s_lo = {p_lo[30:0], 1'b1};
            end else begin
                s_hi = d_shift[31:0];
                s_lo = {p_lo[30:0], 1'b0};
            end
        end else begin
            // Shift-add step: the carry of the add re-enters at the top.
            s_hi = m_add[32:1];
            s_lo = {m_add[0], p_lo[31:1]};
        end
    end

    // Divisor select: for division b_mag holds the divisor
    function automatic logic [31:0] a_mag_or_div();
        return b_mag;
    endfunction

    // Completion and sign correction
    logic        div_zero;
    logic        last;
    logic [63:0] prod;
    logic [31:0] r_hi, r_lo;
    logic        r_dbz;

    assign div_zero = is_div && (b_mag == 32'd0);
    assign last     = (count == 5'd31) || div_zero;
    assign prod     = {s_hi, s_lo};

    always_comb begin
        r_hi  = 32'd0;
        r_lo  = 32'd0;
        r_dbz = 1'b0;
        if (div_zero) begin
            // hi returns the original dataa, rebuilt from its magnitude and sign
            r_hi  = neg_r ? (32'd0 - a_mag) : a_mag;
            r_lo  = 32'hFFFF_FFFF;
            r_dbz = 1'b1;
        end else if (is_div) begin
            r_lo = neg_q ? (32'd0 - s_lo) : s_lo;
            r_hi = neg_r ? (32'd0 - s_hi) : s_hi;
        end else begin
            {r_hi, r_lo} = neg_q ? (64'd0 - prod) : prod;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = S_FIN;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= 5'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a_mag  <= 32'd0;
            b_mag  <= 32'd0;
            p_hi   <= 32'd0;
            p_lo   <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            dbz    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                is_div <= op[1];
                neg_q  <= op_signed && (dataa[31] ^ datab[31]);
                neg_r  <= op_signed && op[1] && dataa[31];
                a_mag  <= abs_a;
                b_mag  <= abs_b;
                count  <= 5'd0;
                p_hi   <= 32'd0;
                // Division shifts the dividend out of p_lo; multiply shifts the
                // multiplier out of p_lo while b_mag is added in.
                p_lo   <= op[1] ? abs_a : abs_a_or_mult(abs_a);
                if (!op[1]) b_mag <= abs_b;
            end else if (state == S_RUN) begin
                count <= count + 5'd1;
                p_hi  <= s_hi;
                p_lo  <= s_lo;
                if (last) begin
                    hi  <= r_hi;
                    lo  <= r_lo;
                    dbz <= r_dbz;
                end
            end
        end
    end

    // Multiplier operand placed in p_lo (product is symmetric; dataa is used)
    function automatic logic [31:0] abs_a_or_mult(input logic [31:0] v);
        return v;
    endfunction

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dataa, datab;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_bad    = 0;

    logic [31:0] last_hi, last_lo;
    logic        last_dbz;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .dataa (dataa),
        .datab (datab),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .hi    (hi),
        .lo    (lo)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one operation, wait for done and check the result.
    // poke_at != 0 pulses a stray start at edge k+poke_at.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] eh,
                          input logic [31:0] el, input logic ed, input int poke_at);
        int j;
        @(negedge clk);
        start = 1'b1; op = o; dataa = a; datab = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; dataa = $urandom; datab = $urandom;
        check({tag, "_busy"}, {64'd0, busy}, 65'd1);
        check({tag, "_hold"}, {dbz, hi, lo}, {last_dbz, last_hi, last_lo});
        j = 0;
        while (done !== 1'b1 && j < 100) begin
            if (poke_at != 0 && j == poke_at - 1) begin
                start = 1'b1;
                op    = 2'b01;
            end
            @(posedge clk);
            @(negedge clk);
            j++;
            start = 1'b0;
            if (poke_at != 0 && j == poke_at)
                check({tag, "_poke_busy"}, {64'd0, busy}, 65'd1);
        end
        check({tag, "_lat"}, 65'(j), 65'(exp_lat));
        check({tag, "_res"}, {dbz, hi, lo}, {ed, eh, el});
        check({tag, "_fin_busy"}, {64'd0, busy}, 65'd0);
        last_hi = eh; last_lo = el; last_dbz = ed;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_once"}, {64'd0, done}, 65'd0);
    endtask

    initial begin
        int j;
        int dones;
        reset = 1'b1; start = 1'b0; op = 2'b00; dataa = 32'd0; datab = 32'd0;
        last_hi = 32'd0; last_lo = 32'd0; last_dbz = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {busy, done, dbz, hi, lo}, 67'd0);
        reset = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
        run_op("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'h00000007, 32, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
        run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 5);
        run_op("divu_by0", 2'b11, 32'h00000005, 32'h00000000, 1, 32'h00000005, 32'hFFFFFFFF, 1'b1, 0);
        run_op("multu_2x3", 2'b01, 32'h00000002, 32'h00000003, 32, 32'h00000000, 32'h00000006, 1'b0, 0);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32, 32'h00000000, 32'h80000000, 1'b0, 0);
        run_op("div_7_m2", 2'b10, 32'h00000007, 32'hFFFFFFFE, 32, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0);
        run_op("div_m7_m2", 2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32, 32'hFFFFFFFF, 32'h00000003, 1'b0, 0);
        run_op("mult_min_sq", 2'b00, 32'h80000000, 32'h80000000, 32, 32'h40000000, 32'h00000000, 1'b0, 0);
        run_op("divu_max_10", 2'b11, 32'hFFFFFFFF, 32'h0000000A, 32, 32'h00000005, 32'h19999999, 1'b0, 0);
        run_op("div_m5_by0", 2'b10, 32'hFFFFFFFB, 32'h00000000, 1, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 0);
        run_op("mult_m1x1", 2'b00, 32'hFFFFFFFF, 32'h00000001, 32, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);

        // back-to-back: MULTU 2x3, then DIVU 100/7 started during FIN
        @(negedge clk);
        start = 1'b1; op = 2'b01; dataa = 32'd2; datab = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        j = 0;
        while (done !== 1'b1 && j < 100) begin
            @(posedge clk); @(negedge clk); j++;
        end
        check("b2b_first_lat", 65'(j), 65'd32);
        check("b2b_first_res", {dbz, hi, lo}, {1'b0, 32'd0, 32'd6});
        start = 1'b1; op = 2'b11; dataa = 32'd100; datab = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_rebusy", {63'd0, busy, done}, 65'b10);
        j = 0;
        while (done !== 1'b1 && j < 100) begin
            @(posedge clk); @(negedge clk); j++;
        end
        check("b2b_second_lat", 65'(j), 65'd32);
        check("b2b_second_res", {dbz, hi, lo}, {1'b0, 32'h00000002, 32'h0000000E});

        // reset in the middle of MULTU 2x3
        @(negedge clk);
        start = 1'b1; op = 2'b01; dataa = 32'd2; datab = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("rst_abort", {busy, done, dbz, hi, lo}, 67'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("rst_no_done", 65'(dones), 65'd0);
        last_hi = 32'd0; last_lo = 32'd0; last_dbz = 1'b0;

        run_op("after_rst", 2'b01, 32'h00000007, 32'h00000006, 32, 32'h00000000, 32'h0000002A, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 Port clk, input, 1 bit: single clock, all state updates on posedge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request a new operation; sampled on a posedge only.
REQ-005 Port op, input, 2 bits: operation select, sampled with start.
- 00 = MULT (signed).
- 01 = MULTU (unsigned).
- 10 = DIV (signed).
- 11 = DIVU (unsigned).
REQ-006 Port dataa, input, 32 bits: multiplicand or dividend (register-file read data 1), sampled with start.
REQ-007 Port datab, input, 32 bits: multiplier or divisor (register-file read data 2), sampled with start.
REQ-008 Port busy, output, 1 bit: an operation is in progress.
REQ-009 Port done, output, 1 bit: single-cycle pulse marking that hi and lo have just been updated.
REQ-010 Port dbz, output, 1 bit: divide-by-zero flag of the last completed operation.
REQ-011 Port hi, output, 32 bits: product upper word, or remainder.
REQ-012 Port lo, output, 32 bits: product lower word, or quotient.

Function
REQ-013 The FSM SHALL have three states.
- IDLE: busy=0.
- RUN: busy=1.
- FIN: busy=0, done=1.
REQ-014 A start SHALL be accepted only when busy=0 (IDLE or FIN); start while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-015 On acceptance at posedge k, the block SHALL:
- latch op and the operand magnitudes (absolute values for signed ops) plus the result sign;
- clear the iteration counter;
- set busy=1.
REQ-016 In RUN, one iteration per posedge, 32 iterations in total.
- Multiply: shift-add.
- Divide: restoring, one quotient bit per cycle.
REQ-017 At posedge k+32 the block SHALL:
- write the sign-corrected result to hi/lo;
- update dbz;
- set busy=0 and done=1, entering FIN.
done SHALL be high only for the cycle following that edge.
REQ-018 FIN SHALL return to IDLE on the next posedge, or to RUN if start is asserted in that cycle (back-to-back operation).
REQ-019 MULT/MULTU: {hi,lo} SHALL be the exact 64-bit product, two's-complement for MULT.
REQ-020 DIV/DIVU: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend (DIV).
REQ-021 Divisor = 0 (DIV or DIVU): the block SHALL skip iteration and complete at posedge k+1.
- lo = 32'hFFFFFFFF, hi = dataa, dbz = 1.
- done pulses in the cycle after that edge.
REQ-022 DIV with 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0, dbz = 0, normal 32-cycle latency.
REQ-023 dbz SHALL be 0 for every completed operation except the case in REQ-021.
REQ-024 hi, lo and dbz SHALL hold their values from completion until the next completion; acceptance of a new start SHALL NOT alter them.
REQ-025 Operand inputs SHALL be ignored after the acceptance edge; changing dataa/datab mid-operation SHALL NOT affect the result.

Reset
REQ-026 While reset=1, regardless of clk, the block SHALL force:
- state = IDLE, iteration counter = 0;
- busy = 0, done = 0, dbz = 0;
- hi = 32'h0, lo = 32'h0.
REQ-027 Reset asserted mid-operation SHALL abort the operation; no done pulse and no hi/lo update from that operation SHALL follow.
REQ-028 After reset deasserts, the first posedge with start=1 SHALL be accepted.

Verification
REQ-029 MULTU, dataa=FFFFFFFF, datab=FFFFFFFF -> done in the cycle after edge k+32; hi=FFFFFFFE, lo=00000001, dbz=0.
REQ-030 MULT, dataa=FFFFFFFD (-3), datab=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB.
REQ-031 DIV, dataa=FFFFFFF9 (-7), datab=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; second start pulsed at edge k+5 is ignored (busy stays 1, single done).
REQ-032 DIVU, dataa=00000005, datab=0 -> done after edge k+1; dbz=1, hi=00000005, lo=FFFFFFFF; next MULTU 2x3 clears dbz and gives hi=0, lo=6.
REQ-033 Start MULTU 2x3, assert reset at edge k+10 -> immediately busy=0, hi=lo=0; no done for the next 40 cycles.
REQ-034 Back-to-back test: start held high during the FIN cycle with DIVU 100/7 -> busy reasserts with no IDLE cycle; result lo=0000000E, hi=00000002.
